// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer bank scheduler.
// Purpose: frame geometry constants, the bank index type and the
// scheduler state encoding used by every file of the block.
// Ports: none (package).
package fb_pkg;

  localparam int H_RES       = 640;
  localparam int V_RES       = 480;
  localparam int FRAME_WORDS = H_RES * V_RES;

  typedef logic [1:0] bank_idx_t;

  typedef enum logic {
    CAPTURE   = 1'b0,
    WAIT_FREE = 1'b1
  } state_t;

endpackage

// File: rtl/fb_bank_sched_if.sv
// Bus between the bank scheduler and its surroundings.
// Purpose: bundles the capture handshake, the display vsync and the
// bank/base-address outputs.
// Ports (signals):
//   cap_frame_done  capture writer finished the current bank (pulse)
//   disp_vsync      display vertical sync level, active low
//   cap_enable      writer may fill wr_bank
//   wr_bank/rd_bank bank indices being written / displayed
//   wr_base/rd_base base addresses of those banks
//   frame_ready     a finished, not yet displayed bank is pending
//   drop_count      frames discarded before display
// Modports: master = scheduler, slave = capture/display side.
interface fb_bank_sched_if #(
  parameter int ADDR_W = 20
);
  import fb_pkg::*;

  logic              cap_frame_done;
  logic              disp_vsync;
  logic              cap_enable;
  bank_idx_t         wr_bank;
  bank_idx_t         rd_bank;
  logic [ADDR_W-1:0] wr_base;
  logic [ADDR_W-1:0] rd_base;
  logic              frame_ready;
  logic [15:0]       drop_count;

  modport master (
    input  cap_frame_done, disp_vsync,
    output cap_enable, wr_bank, rd_bank, wr_base, rd_base,
           frame_ready, drop_count
  );

  modport slave (
    output cap_frame_done, disp_vsync,
    input  cap_enable, wr_bank, rd_bank, wr_base, rd_base,
           frame_ready, drop_count
  );

endinterface

// File: rtl/fb_bank_base.sv
// Registered bank-index to base-address lookup.
// Purpose: turns a bank index into bank*FRAME_WORDS with a constant
// mux (no multiplier). Fed with the scheduler's next bank index so the
// base lands in the same cycle as the registered index.
// Ports:
//   clk25      pixel clock
//   reset_n    synchronous active-low reset (base <= RESET_BANK base)
//   bank       next bank index
//   base       registered base address
module fb_bank_base
  import fb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int FRAME_WORDS = 307200,
  parameter int RESET_BANK  = 0
) (
  input  logic              clk25,
  input  logic              reset_n,
  input  bank_idx_t         bank,
  output logic [ADDR_W-1:0] base
);

  localparam logic [ADDR_W-1:0] BASE0      = '0;
  localparam logic [ADDR_W-1:0] BASE1      = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BASE2      = ADDR_W'(2 * FRAME_WORDS);
  localparam logic [ADDR_W-1:0] RESET_BASE = ADDR_W'(RESET_BANK * FRAME_WORDS);

  logic [ADDR_W-1:0] base_n;

  always_comb begin
    base_n = BASE0;
    case (bank)
      2'd1:    base_n = BASE1;
      2'd2:    base_n = BASE2;
      default: base_n = BASE0;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (!reset_n) base <= RESET_BASE;
    else          base <= base_n;
  end

endmodule

// File: rtl/fb_bank_sched.sv
// Frame-buffer bank scheduler (double or triple buffering).
// Purpose: hands the capture writer a bank to fill and the VGA reader a
// completed bank, swapping the read bank only on the vsync falling edge
// so scan-out never tears.
// Ports:
//   clk25    25 MHz pixel clock (sole clock)
//   reset_n  synchronous active-low reset
//   bus      fb_bank_sched_if.master (see interface header)
// Parameters: NUM_BANKS (2 or 3), FRAME_WORDS, ADDR_W.
// Optional feature: define FB_DROP_CNT_EN to count frames dropped in
// triple-buffer mode; otherwise drop_count is tied to zero.
module fb_bank_sched
  import fb_pkg::*;
#(
  parameter int NUM_BANKS   = 3,
  parameter int FRAME_WORDS = 307200,
  parameter int ADDR_W      = 20
) (
  input logic           clk25,
  input logic           reset_n,
  fb_bank_sched_if.master bus
);

  state_t    state_q, state_n;
  bank_idx_t wr_q, wr_n;
  bank_idx_t rd_q, rd_n;
  // In 3-bank mode this is the completed bank when frame_ready=1 and the
  // free bank otherwise, so it always names the one bank not in use.
  bank_idx_t rdy_q, rdy_n;
  logic      ready_q, ready_n;
  logic      cap_en_q, cap_en_n;
  logic      vs_q;
  logic      vs_edge;
  logic      drop;

  assign vs_edge = vs_q & ~bus.disp_vsync;

  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      state_q  <= CAPTURE;
      wr_q     <= 2'd1;
      rd_q     <= 2'd0;
      rdy_q    <= 2'd2;
      ready_q  <= 1'b0;
      cap_en_q <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      state_q  <= state_n;
      wr_q     <= wr_n;
      rd_q     <= rd_n;
      rdy_q    <= rdy_n;
      ready_q  <= ready_n;
      cap_en_q <= cap_en_n;
      vs_q     <= bus.disp_vsync;
    end
  end

  // The done update is applied first; the vsync swap then works on the
  // resulting ready bank so a frame finished on the edge is shown.
  always_comb begin
    state_n  = state_q;
    wr_n     = wr_q;
    rd_n     = rd_q;
    rdy_n    = rdy_q;
    ready_n  = ready_q;
    cap_en_n = cap_en_q;
    drop     = 1'b0;

    if (state_q == CAPTURE && bus.cap_frame_done) begin
      if (NUM_BANKS == 3) begin
        // Writer takes the other non-displayed bank either way; with a
        // frame already pending this discards the older one.
        wr_n    = rdy_q;
        rdy_n   = wr_q;
        drop    = ready_q;
        ready_n = 1'b1;
      end else begin
        rdy_n    = wr_q;
        ready_n  = 1'b1;
        cap_en_n = 1'b0;
        state_n  = WAIT_FREE;
      end
    end

    if (vs_edge && ready_n) begin
      rd_n    = rdy_n;
      ready_n = 1'b0;
      if (NUM_BANKS == 3) begin
        rdy_n = rd_q;
      end else begin
        wr_n     = rd_q;
        cap_en_n = 1'b1;
        state_n  = CAPTURE;
      end
    end
  end

  fb_bank_base #(
    .ADDR_W     (ADDR_W),
    .FRAME_WORDS(FRAME_WORDS),
    .RESET_BANK (1)
  ) u_wr_base (
    .clk25  (clk25),
    .reset_n(reset_n),
    .bank   (wr_n),
    .base   (bus.wr_base)
  );

  fb_bank_base #(
    .ADDR_W     (ADDR_W),
    .FRAME_WORDS(FRAME_WORDS),
    .RESET_BANK (0)
  ) u_rd_base (
    .clk25  (clk25),
    .reset_n(reset_n),
    .bank   (rd_n),
    .base   (bus.rd_base)
  );

  assign bus.wr_bank     = wr_q;
  assign bus.rd_bank     = rd_q;
  assign bus.frame_ready = ready_q;
  assign bus.cap_enable  = cap_en_q;

`ifdef FB_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of discarded frames.
  always_ff @(posedge clk25) begin
    if (!reset_n)                          drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign bus.drop_count = drop_cnt_q;
`else
  logic drop_unused;
  assign drop_unused    = drop;
  assign bus.drop_count = '0;
`endif

endmodule

// File: tb/tb_fb_bank_sched.sv
// Directed testbench for fb_bank_sched: one triple-buffer and one
// double-buffer instance driven side by side with hand-computed
// expected values.
module tb_fb_bank_sched;

  localparam int FW = 307200;
`ifdef FB_DROP_CNT_EN
  localparam int DROP_EXP = 1;
`else
  localparam int DROP_EXP = 0;
`endif

  logic clk25;
  logic reset_n;
  int   tests;
  int   errors;

  fb_bank_sched_if #(.ADDR_W(20)) bus3 ();
  fb_bank_sched_if #(.ADDR_W(20)) bus2 ();

  fb_bank_sched #(.NUM_BANKS(3), .FRAME_WORDS(FW), .ADDR_W(20)) dut3 (
    .clk25  (clk25),
    .reset_n(reset_n),
    .bus    (bus3)
  );

  fb_bank_sched #(.NUM_BANKS(2), .FRAME_WORDS(FW), .ADDR_W(20)) dut2 (
    .clk25  (clk25),
    .reset_n(reset_n),
    .bus    (bus2)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  // Drive one cycle of inputs at the falling edge, then sample just
  // after the following rising edge.
  task automatic applyStimulus(input logic rst_n, input logic d3, input logic v3,
                               input logic d2, input logic v2);
    @(negedge clk25);
    reset_n             = rst_n;
    bus3.cap_frame_done = d3;
    bus3.disp_vsync     = v3;
    bus2.cap_frame_done = d2;
    bus2.disp_vsync     = v2;
    @(posedge clk25);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    reset_n = 1'b0;
    bus3.cap_frame_done = 1'b0;
    bus3.disp_vsync     = 1'b1;
    bus2.cap_frame_done = 1'b0;
    bus2.disp_vsync     = 1'b1;

    // Reset state of both instances
    doReset();
    checkOutput("rst3_rd", int'(bus3.rd_bank), 0);
    checkOutput("rst3_wr", int'(bus3.wr_bank), 1);
    checkOutput("rst3_rdy", int'(bus3.frame_ready), 0);
    checkOutput("rst3_cap", int'(bus3.cap_enable), 1);
    checkOutput("rst3_rdbase", int'(bus3.rd_base), 0);
    checkOutput("rst3_wrbase", int'(bus3.wr_base), FW);
    checkOutput("rst3_drop", int'(bus3.drop_count), 0);
    checkOutput("rst2_wr", int'(bus2.wr_bank), 1);
    checkOutput("rst2_cap", int'(bus2.cap_enable), 1);

    // Idle: three vsync falls with nothing pending change nothing
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("idle_rd", int'(bus3.rd_bank), 0);
      checkOutput("idle_wr", int'(bus3.wr_bank), 1);
      checkOutput("idle_rdy", int'(bus3.frame_ready), 0);
      checkOutput("idle_cap", int'(bus3.cap_enable), 1);
      checkOutput("idle_rdbase", int'(bus3.rd_base), 0);
      checkOutput("idle_wrbase", int'(bus3.wr_base), FW);
      checkOutput("idle2_rd", int'(bus2.rd_bank), 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    end

    // Triple buffer: done then vsync fall
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_done_wr", int'(bus3.wr_bank), 2);
    checkOutput("t3_done_wrbase", int'(bus3.wr_base), 2 * FW);
    checkOutput("t3_done_rdy", int'(bus3.frame_ready), 1);
    checkOutput("t3_done_rd", int'(bus3.rd_bank), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_vs_rd", int'(bus3.rd_bank), 1);
    checkOutput("t3_vs_rdbase", int'(bus3.rd_base), FW);
    checkOutput("t3_vs_rdy", int'(bus3.frame_ready), 0);
    checkOutput("t3_vs_wr", int'(bus3.wr_bank), 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // Freed bank 0 is handed to the writer on the next done
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_free_wr", int'(bus3.wr_bank), 0);
    checkOutput("t3_free_wrbase", int'(bus3.wr_base), 0);

    // Triple buffer: two dones before a vsync fall drops one frame
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("drop_first_wr", int'(bus3.wr_bank), 2);
    checkOutput("drop_first_cnt", int'(bus3.drop_count), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("drop_second_wr", int'(bus3.wr_bank), 1);
    checkOutput("drop_second_rdy", int'(bus3.frame_ready), 1);
    checkOutput("drop_second_cnt", int'(bus3.drop_count), DROP_EXP);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("drop_vs_rd", int'(bus3.rd_bank), 2);
    checkOutput("drop_vs_rdbase", int'(bus3.rd_base), 2 * FW);
    checkOutput("drop_vs_wr", int'(bus3.wr_bank), 1);
    checkOutput("drop_vs_rdy", int'(bus3.frame_ready), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // Double buffer: done stalls writer, extra done ignored, vsync swaps
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("d2_done_cap", int'(bus2.cap_enable), 0);
    checkOutput("d2_done_rdy", int'(bus2.frame_ready), 1);
    checkOutput("d2_done_wr", int'(bus2.wr_bank), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("d2_extra_cap", int'(bus2.cap_enable), 0);
    checkOutput("d2_extra_wr", int'(bus2.wr_bank), 1);
    checkOutput("d2_extra_rd", int'(bus2.rd_bank), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("d2_vs_rd", int'(bus2.rd_bank), 1);
    checkOutput("d2_vs_wr", int'(bus2.wr_bank), 0);
    checkOutput("d2_vs_cap", int'(bus2.cap_enable), 1);
    checkOutput("d2_vs_rdy", int'(bus2.frame_ready), 0);
    checkOutput("d2_vs_rdbase", int'(bus2.rd_base), FW);
    checkOutput("d2_vs_wrbase", int'(bus2.wr_base), 0);
    checkOutput("d2_drop", int'(bus2.drop_count), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // Done and vsync fall in the same cycle, both instances
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("sim2_rd", int'(bus2.rd_bank), 1);
    checkOutput("sim2_wr", int'(bus2.wr_bank), 0);
    checkOutput("sim2_cap", int'(bus2.cap_enable), 1);
    checkOutput("sim2_rdy", int'(bus2.frame_ready), 0);
    checkOutput("sim3_rd", int'(bus3.rd_bank), 1);
    checkOutput("sim3_wr", int'(bus3.wr_bank), 2);
    checkOutput("sim3_rdy", int'(bus3.frame_ready), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("sim3_next_wr", int'(bus3.wr_bank), 0);
    checkOutput("sim3_next_drop", int'(bus3.drop_count), 0);

    // Reset pulse while the double buffer waits for a free bank
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("mid_pre_cap", int'(bus2.cap_enable), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("mid_rst_cap", int'(bus2.cap_enable), 1);
    checkOutput("mid_rst_rdy", int'(bus2.frame_ready), 0);
    checkOutput("mid_rst_wr", int'(bus2.wr_bank), 1);
    checkOutput("mid_rst_rd", int'(bus2.rd_bank), 0);
    checkOutput("mid_rst_wrbase", int'(bus2.wr_base), FW);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_vs_rd", int'(bus2.rd_bank), 0);
    checkOutput("mid_vs_cap", int'(bus2.cap_enable), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("mid_capture_cap", int'(bus2.cap_enable), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/fb_bank_sched.md
Name: fb_bank_sched

Overview:
- Schedules a multi-bank frame buffer shared between the camera capture writer and the VGA display reader.
- Hands the writer a bank to fill and the reader a completed bank to scan out.
- Swaps the read bank only on the display's vertical-sync falling edge, so scan-out never tears.
- Sits between the capture path, the frame memory address generators, and the 640x480 VGA timing block.

Parameters:
- NUM_BANKS, 3, bank count; legal values 2 (double buffer) or 3 (triple buffer)
- FRAME_WORDS, 307200, pixels per frame (640*480, one 12-bit word each)
- ADDR_W, 20, width of base-address outputs; must hold NUM_BANKS*FRAME_WORDS-1

Ports:
- clk25  in  1  25 MHz pixel clock; sole clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk25
- cap_frame_done  in  1  one-cycle pulse: writer finished last pixel of current wr bank
- disp_vsync  in  1  display vertical sync level, active low
- cap_enable  out  1  writer may start/continue a frame into wr_bank
- wr_bank  out  2  bank index being written
- rd_bank  out  2  bank index being displayed
- wr_base  out  ADDR_W  wr_bank*FRAME_WORDS
- rd_base  out  ADDR_W  rd_bank*FRAME_WORDS
- frame_ready  out  1  a completed, not-yet-displayed bank is pending
- drop_count  out  16  frames discarded before display (see Optional Feature)

Behaviour:
- Reset: rd_bank=0, wr_bank=1, ready bank=2 with frame_ready=0, cap_enable=1, wr_base=FRAME_WORDS, rd_base=0, drop_count=0, vsync history=1, state CAPTURE.
- All outputs are registered and change on the clock edge after the event is sampled (latency 1).
- Vsync edge: vs_edge = vs_q & ~disp_vsync; vs_q <= disp_vsync every cycle.
- Base addresses come from a constant mux on the bank index, with no multiplier. Each base updates in the same cycle as its bank index.
- States are CAPTURE and WAIT_FREE. WAIT_FREE is reachable only when NUM_BANKS=2.
- CAPTURE, cap_frame_done:
  - 3 banks, frame_ready=0: ready<=wr_bank, wr_bank<=third bank, frame_ready<=1.
  - 3 banks, frame_ready=1: swap wr_bank and the ready bank; this drops the older completed frame. frame_ready stays 1.
  - 2 banks: ready<=wr_bank, frame_ready<=1, cap_enable<=0, go to WAIT_FREE.
- vs_edge with frame_ready=1:
  - rd_bank<=ready and frame_ready<=0.
  - 3 banks: the old rd bank becomes the free bank.
  - 2 banks: wr_bank<=old rd_bank, cap_enable<=1, go to CAPTURE.
- vs_edge with frame_ready=0: no change; the display repeats the current frame.
- Simultaneous cap_frame_done and vs_edge:
  - The done update is applied first; the swap then uses the resulting ready bank, so the just-finished frame is displayed.
  - 2 banks: net effect is rd<=old wr, wr<=old rd, cap_enable stays 1, state stays CAPTURE.
- cap_frame_done in WAIT_FREE: ignored, with no state change. The writer must not write while cap_enable=0.
- Invariant: rd_bank, wr_bank and the ready bank (3 banks) are always pairwise distinct.
- Reset asserted mid-frame: all state returns to reset values on the next edge. Any pending ready frame is discarded without counting as a drop.

Optional Feature:
- Macro: FB_DROP_CNT_EN.
- Defined: drop_count increments on each drop event (3-bank done with frame_ready=1), saturating at 16'hFFFF. It resets to 0.
- Undefined: no counter logic; drop_count tied to 0.

Decomposition:
- Shared package fb_pkg holds:
  - constants H_RES=640, V_RES=480, FRAME_WORDS;
  - typedef bank_idx_t (2 bits);
  - state enum {CAPTURE, WAIT_FREE}.
- Sub-module: fb_bank_base, a registered bank-to-base-address mux. It is instantiated twice, once for wr_base and once for rd_base.

Test Plan:
- Reset then idle 3 vsync edges -> rd_bank=0, wr_bank=1, frame_ready=0, cap_enable=1, rd_base=0, wr_base=307200 throughout.
- NUM_BANKS=3: done pulse, then vsync fall -> after done wr_bank=2, frame_ready=1; after edge rd_bank=1, rd_base=307200, frame_ready=0.
- NUM_BANKS=3: two done pulses before any vsync fall -> second pulse gives wr_bank=1, ready=2, drop_count=1 (0 without FB_DROP_CNT_EN); next edge gives rd_bank=2.
- NUM_BANKS=2: done pulse -> cap_enable=0, WAIT_FREE. Extra done ignored. Vsync fall -> rd_bank=1, wr_bank=0, cap_enable=1.
- Done and vsync fall in the same cycle (NUM_BANKS=2, from reset) -> next cycle rd_bank=1, wr_bank=0, cap_enable=1, frame_ready=0.
- reset_n low for one cycle mid-WAIT_FREE -> next cycle all reset values, state CAPTURE.
